// File: rtl/mctrl_pkg.sv
// Shared constants for multicycle_ctrl: opcodes, state encodings, trap causes
// and ALU function codes.
package mctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b100000;
  localparam logic [5:0] OP_LI    = 6'b111000;
  localparam logic [5:0] OP_LUI   = 6'b111001;
  localparam logic [5:0] OP_ADDI  = 6'b110000;
  localparam logic [5:0] OP_ANDI  = 6'b110010;
  localparam logic [5:0] OP_ORI   = 6'b110011;
  localparam logic [5:0] OP_B     = 6'b111111;
  localparam logic [5:0] OP_BEQ   = 6'b000000;
  localparam logic [5:0] OP_BNE   = 6'b000001;
  localparam logic [5:0] OP_LB    = 6'b000011;
  localparam logic [5:0] OP_LW    = 6'b001111;
  localparam logic [5:0] OP_SB    = 6'b000111;
  localparam logic [5:0] OP_SW    = 6'b011111;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'b000,
    ST_DECODE = 3'b001,
    ST_EXEC   = 3'b010,
    ST_MEM    = 3'b011,
    ST_WB     = 3'b100,
    ST_TRAP   = 3'b111
  } state_t;

  typedef enum logic [1:0] {
    CAUSE_NONE    = 2'b00,
    CAUSE_ILLEGAL = 2'b01,
    CAUSE_IMEM    = 2'b10,
    CAUSE_DMEM    = 2'b11
  } cause_t;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_OR  = 4'b0011;

endpackage

// File: rtl/mctrl_decode.sv
// Combinational opcode decoder: instruction class flags and ALU function.
module mctrl_decode
  import mctrl_pkg::*;
#(
  parameter int INSTR_W = 32,
  parameter int FUNC_W  = 4
) (
  input  logic [INSTR_W-1:0] instr_i,
  output logic               is_rtype_o,
  output logic               is_imm_o,
  output logic               is_branch_o,
  output logic               is_load_o,
  output logic               is_store_o,
  output logic               is_nop_o,
  output logic               is_illegal_o,
  output logic               is_b_o,
  output logic               is_beq_o,
  output logic               is_bne_o,
  output logic               is_byte_o,
  output logic [FUNC_W-1:0]  alu_func_o
);

  logic [5:0] opcode;
  assign opcode = instr_i[INSTR_W-1 -: 6];

  always_comb begin
    is_rtype_o   = 1'b0;
    is_imm_o     = 1'b0;
    is_branch_o  = 1'b0;
    is_load_o    = 1'b0;
    is_store_o   = 1'b0;
    is_illegal_o = 1'b0;
    is_b_o       = 1'b0;
    is_beq_o     = 1'b0;
    is_bne_o     = 1'b0;
    is_byte_o    = 1'b0;
    alu_func_o   = FUNC_W'(ALU_ADD);
    // An all-zero word shares the beq opcode, so nop must be filtered first
    is_nop_o     = (instr_i == '0);
    if (!is_nop_o) begin
      case (opcode)
        OP_RTYPE: begin
          is_rtype_o = 1'b1;
          alu_func_o = instr_i[FUNC_W-1:0];
        end
        OP_LI, OP_LUI, OP_ADDI: is_imm_o = 1'b1;
        OP_ANDI: begin
          is_imm_o   = 1'b1;
          alu_func_o = FUNC_W'(ALU_AND);
        end
        OP_ORI: begin
          is_imm_o   = 1'b1;
          alu_func_o = FUNC_W'(ALU_OR);
        end
        OP_B: begin
          is_branch_o = 1'b1;
          is_b_o      = 1'b1;
        end
        OP_BEQ: begin
          is_branch_o = 1'b1;
          is_beq_o    = 1'b1;
          alu_func_o  = FUNC_W'(ALU_SUB);
        end
        OP_BNE: begin
          is_branch_o = 1'b1;
          is_bne_o    = 1'b1;
          alu_func_o  = FUNC_W'(ALU_SUB);
        end
        OP_LB: begin
          is_load_o = 1'b1;
          is_byte_o = 1'b1;
        end
        OP_LW: is_load_o = 1'b1;
        OP_SB: begin
          is_store_o = 1'b1;
          is_byte_o  = 1'b1;
        end
        OP_SW: is_store_o = 1'b1;
        default: is_illegal_o = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle processor control FSM with memory handshakes and trapping.
// Define MULTICYCLE_CTRL_PERF_EN to build the cycle/retired performance counters.
//
// state  | meaning
// FETCH  | request instruction, wait for IMEM_ready
// DECODE | classify opcode (nop retires, illegal traps)
// EXEC   | ALU operation; branches resolve and retire here
// MEM    | data access, wait for DMEM_ready
// WB     | register file write, retire
// TRAP   | halted until Reset
module multicycle_ctrl
  import mctrl_pkg::*;
#(
  parameter int INSTR_W  = 32,
  parameter int FUNC_W   = 4,
  parameter int MAX_WAIT = 15,
  parameter int CNT_W    = 32
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic [INSTR_W-1:0] Instr,
  input  logic               ALU_zero,
  input  logic               IMEM_ready,
  input  logic               DMEM_ready,
  output logic               IMEM_req,
  output logic               IR_LdEn,
  output logic               DMEM_req,
  output logic               PC_LdEn,
  output logic               PC_sel,
  output logic               RF_B_sel,
  output logic               RF_WrEn,
  output logic               RF_WrData_sel,
  output logic               ALU_Bin_sel,
  output logic               MEM_we,
  output logic               MEM_In_sel,
  output logic               MEM_Out_sel,
  output logic [FUNC_W-1:0]  ALU_func,
  output logic               Trap,
  output logic [1:0]         Trap_cause,
  output logic [2:0]         State,
  output logic [CNT_W-1:0]   Cycle_cnt,
  output logic [CNT_W-1:0]   Retired_cnt
);

  localparam int WAIT_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;

  state_t            state_q, state_d;
  cause_t            cause_q, cause_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              timeout;
  logic is_rtype, is_imm, is_branch, is_load, is_store, is_nop, is_illegal;
  logic is_b, is_beq, is_bne, is_byte;

  mctrl_decode #(
    .INSTR_W (INSTR_W),
    .FUNC_W  (FUNC_W)
  ) u_decode (
    .instr_i      (Instr),
    .is_rtype_o   (is_rtype),
    .is_imm_o     (is_imm),
    .is_branch_o  (is_branch),
    .is_load_o    (is_load),
    .is_store_o   (is_store),
    .is_nop_o     (is_nop),
    .is_illegal_o (is_illegal),
    .is_b_o       (is_b),
    .is_beq_o     (is_beq),
    .is_bne_o     (is_bne),
    .is_byte_o    (is_byte),
    .alu_func_o   (ALU_func)
  );

  // Fires on the wait cycle that would make the count reach MAX_WAIT; ready wins.
  assign timeout = (MAX_WAIT > 0) && (wait_q == WAIT_W'(MAX_WAIT - 1));

  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    wait_d  = '0;
    case (state_q)
      ST_FETCH: begin
        if (IMEM_ready) state_d = ST_DECODE;
        else if (timeout) begin
          state_d = ST_TRAP;
          cause_d = CAUSE_IMEM;
        end else wait_d = wait_q + WAIT_W'(1);
      end
      ST_DECODE: begin
        if (is_nop) state_d = ST_FETCH;
        else if (is_illegal) begin
          state_d = ST_TRAP;
          cause_d = CAUSE_ILLEGAL;
        end else state_d = ST_EXEC;
      end
      ST_EXEC: begin
        if (is_branch) state_d = ST_FETCH;
        else if (is_load || is_store) state_d = ST_MEM;
        else if (is_rtype || is_imm) state_d = ST_WB;
        else begin
          state_d = ST_TRAP;
          cause_d = CAUSE_ILLEGAL;
        end
      end
      ST_MEM: begin
        if (DMEM_ready) state_d = is_store ? ST_FETCH : ST_WB;
        else if (timeout) begin
          state_d = ST_TRAP;
          cause_d = CAUSE_DMEM;
        end else wait_d = wait_q + WAIT_W'(1);
      end
      ST_WB:   state_d = ST_FETCH;
      ST_TRAP: state_d = ST_TRAP;
      default: begin
        state_d = ST_TRAP;
        cause_d = CAUSE_NONE;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= ST_FETCH;
      cause_q <= CAUSE_NONE;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      wait_q  <= wait_d;
    end
  end

  always_comb begin
    IMEM_req = 1'b0;
    IR_LdEn  = 1'b0;
    DMEM_req = 1'b0;
    PC_LdEn  = 1'b0;
    PC_sel   = 1'b0;
    RF_WrEn  = 1'b0;
    MEM_we   = 1'b0;
    case (state_q)
      ST_FETCH: begin
        IMEM_req = 1'b1;
        IR_LdEn  = IMEM_ready;
      end
      ST_DECODE: PC_LdEn = is_nop;
      ST_EXEC: begin
        PC_LdEn = is_branch;
        PC_sel  = is_b | (is_beq & ALU_zero) | (is_bne & ~ALU_zero);
      end
      ST_MEM: begin
        DMEM_req = 1'b1;
        MEM_we   = is_store;
        PC_LdEn  = is_store & DMEM_ready;
      end
      ST_WB: begin
        RF_WrEn = 1'b1;
        PC_LdEn = 1'b1;
      end
      default: ;
    endcase
    if (Reset) begin
      IMEM_req = 1'b0;
      IR_LdEn  = 1'b0;
      DMEM_req = 1'b0;
      PC_LdEn  = 1'b0;
      PC_sel   = 1'b0;
      RF_WrEn  = 1'b0;
      MEM_we   = 1'b0;
    end
  end

  assign ALU_Bin_sel   = is_imm | is_load | is_store;
  assign RF_B_sel      = is_beq | is_bne | is_store;
  assign RF_WrData_sel = is_load;
  assign MEM_In_sel    = is_store & is_byte;
  assign MEM_Out_sel   = is_load & is_byte;
  assign Trap          = (state_q == ST_TRAP);
  assign Trap_cause    = cause_q;
  assign State         = state_q;

`ifdef MULTICYCLE_CTRL_PERF_EN
  logic [CNT_W-1:0] cycle_q, retired_q;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      cycle_q   <= '0;
      retired_q <= '0;
    end else begin
      if ((state_q != ST_TRAP) && (cycle_q != '1)) cycle_q <= cycle_q + CNT_W'(1);
      if (PC_LdEn && (retired_q != '1)) retired_q <= retired_q + CNT_W'(1);
    end
  end

  assign Cycle_cnt   = cycle_q;
  assign Retired_cnt = retired_q;
`else
  assign Cycle_cnt   = '0;
  assign Retired_cnt = '0;
`endif

endmodule
